aes128_iter_encrypt: RTL and testbench
======================================

# aes128_iter_encrypt

Iterative AES-128 encryption core (FIPS-197) that computes one round per clock with an on-the-fly key schedule. It starts on a rising edge of a level `load` control, so a debounced push-button toggle can drive it directly. It presents the ciphertext with a sticky `valid` flag. It sits between the board-level control logic, which supplies a fixed key, plaintext and `load`, and the display path, which reads `ct`.

## Interface
- `NK`, default 4: key length in 32-bit words. Only 4 (AES-128, 10 rounds) is supported; elaboration fails on any other value.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key`  in  128  cipher key; `key[127:120]` is key byte 0.
- `load`  in  1  start request, level signal; only its 0->1 transition starts an operation.
- `pt`  in  128  plaintext; `pt[127:120]` is state byte 0, column-major per FIPS-197.
- `ct`  out  128  ciphertext, same byte order as `pt`.
- `valid`  out  1  high while `ct` holds the result of the most recent completed operation.

## Operation
- The core keeps a registered copy `load_q` of `load`. A start event is `load & ~load_q` sampled at a clock edge.
- **IDLE state.** On a start event:
  - `state <= pt ^ key` (round 0).
  - `rk <= key`.
  - `round <= 1`.
  - `valid <= 0`.
  - Go to BUSY.
- **BUSY state, `round` = 1..9.**
  - Derive the next round key `rk'` from `rk`: RotWord, then SubWord, then XOR with Rcon[round] (01,02,04,08,10,20,40,80,1b,36), chained XOR across words 1-3.
  - `state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk'`.
  - `rk <= rk'`.
  - `round <= round+1`.
- **BUSY state, `round` = 10.**
  - Compute `ShiftRows(SubBytes(state)) ^ rk'`, with no MixColumns.
  - `ct <=` that result.
  - `valid <= 1`.
  - Return to IDLE.
- S-box: either a 256-entry combinational table or the GF(2^8) inverse plus affine transform. The design needs 16 data S-boxes and 4 key-schedule S-boxes, all combinational.
- `key` and `pt` are sampled only at the start event. Changes to them during BUSY are ignored.
- A start event while BUSY is ignored. `load_q` still tracks `load`, so that edge is consumed.
- `ct` and `valid` hold indefinitely in IDLE. `ct` keeps the old value until the new result is written, and only `valid` drops at the start of a new operation.
- Holding `load` high never restarts the core. Lowering `load` has no effect on `ct` or `valid`.

## Timing
- Reset (`rst_n` = 0 at an edge) sets:
  - `ct` = 0.
  - `valid` = 0.
  - `load_q` = 0.
  - `round` = 0.
  - State = IDLE.
- Reset mid-operation aborts the operation. No result appears.
- If `load` is already high when reset releases, the first post-reset edge counts as a start (`load_q` = 0).
- Latency:
  - Start sampled at edge T0.
  - Rounds are applied at edges T1..T10.
  - `ct` and `valid` update at T10, i.e. 10 cycles after the start edge.
  - `valid` = 0 from T0 until T10.
- Earliest accepted restart: a start event at T11 or later, because it requires `load` to go low and back high while IDLE.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset with `load`=0 -> `ct`=0 and `valid`=0. Both stay 0 for 20 cycles.
- `key`=000102030405060708090a0b0c0d0e0f, `pt`=00112233445566778899aabbccddeeff, `load` 0->1 -> `valid` rises exactly 10 cycles after the start edge, with `ct`=69c4e0d86a7b0430d8cdb78070b4c55a.
- `key`=2b7e151628aed2a6abf7158809cf4f3c, `pt`=3243f6a8885a308d313198a2e0370734 -> internal state after T0 = 193de3bea0f4e22b9ac68d2ae9f84808, and `ct`=3925841d02dc09fbdc118597196a0b32.
- Keep `load` high for 50 cycles after completion -> exactly one operation occurs and `valid` stays 1. Then drop `load` and raise it again -> `valid` falls at the start edge, and the new result arrives 10 cycles later.
- Toggle `load` and change `pt`/`key` during BUSY -> neither affects the result, and `ct` matches the inputs sampled at start.
- Assert `rst_n`=0 at cycle 5 of BUSY -> `valid`=0 and `ct`=0. No result appears until a new start event.

Source files
------------

// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, key schedule on the fly.
// Starts on a rising edge of load; ct/valid hold until the next start.
module aes128_iter_encrypt #(
   parameter int NK = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key,
   input  logic         load,
   input  logic [127:0] pt,
   output logic [127:0] ct,
   output logic         valid
);

   if (NK != 4) begin : g_bad_nk
      $fatal(1, "aes128_iter_encrypt: only NK=4 is supported");
   end

   typedef enum logic {IDLE, BUSY} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic         load_q, load_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] ct_q, ct_d;
   logic         valid_q, valid_d;
   logic         start;
   logic [127:0] rk_next, sr;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // GF(2^8) inverse as b^254, then the FIPS-197 affine map
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x2, x3, x12, x15, x240, inv;
      x2   = gmul(b, b);
      x3   = gmul(x2, b);
      x12  = gmul(x3, x3);
      x12  = gmul(x12, x12);
      x15  = gmul(x12, x3);
      x240 = x15;
      for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
      inv  = gmul(gmul(x240, x12), x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Byte i = row (i%4), column (i/4); byte 0 is the MSB
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[127-8*(r+4*c) -: 8] =
               sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   assign start = load & ~load_q;
   assign sr    = sub_shift(state_q);

   always_comb begin
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon(round_q), 24'h0};
      n0 = rk_q[127:96] ^ t;
      n1 = rk_q[95:64] ^ n0;
      n2 = rk_q[63:32] ^ n1;
      n3 = rk_q[31:0] ^ n2;
      rk_next = {n0, n1, n2, n3};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         load_q  <= 1'b0;
         round_q <= '0;
         state_q <= '0;
         rk_q    <= '0;
         ct_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         load_q  <= load_d;
         round_q <= round_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         ct_q    <= ct_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         IDLE:    if (start) fsm_d = BUSY;
         BUSY:    if (round_q == 4'd10) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      load_d  = load;
      round_d = round_q;
      state_d = state_q;
      rk_d    = rk_q;
      ct_d    = ct_q;
      valid_d = valid_q;
      unique case (fsm_q)
         IDLE: begin
            if (start) begin
               state_d = pt ^ key;
               rk_d    = key;
               round_d = 4'd1;
               valid_d = 1'b0;
            end
         end
         BUSY: begin
            rk_d = rk_next;
            if (round_q == 4'd10) begin
               ct_d    = sr ^ rk_next;
               valid_d = 1'b1;
               round_d = '0;
            end else begin
               state_d = mix_cols(sr) ^ rk_next;
               round_d = round_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   assign ct    = ct_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Directed bench for aes128_iter_encrypt: known-answer vectors plus
// sequences for load hold/retrigger, mid-operation changes and resets.
module tb_aes128_iter_encrypt;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] pt = '0;
   logic [127:0] ct;
   logic         valid;

   int total = 0;
   int bad = 0;
   logic [127:0] last_ct = '0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] st0;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs[3];

   aes128_iter_encrypt #(.NK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key),
      .load  (load),
      .pt    (pt),
      .ct    (ct),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Leaves the bench just after the start edge T0
   task automatic start_op(input logic [127:0] k,
                           input logic [127:0] p);
      load = 1'b0;
      tick();
      key  = k;
      pt   = p;
      load = 1'b1;
      tick();
      check("valid_at_t0", {127'd0, valid}, 128'd0);
   endtask

   // Called after edge T<done>; checks T9 and T10
   task automatic finish_op(input string name,
                            input logic [127:0] exp,
                            input int done);
      repeat (8 - done) tick();
      tick();
      check({name, "_valid_t9"}, {127'd0, valid}, 128'd0);
      check({name, "_ct_t9"}, ct, last_ct);
      tick();
      check({name, "_valid_t10"}, {127'd0, valid}, 128'd1);
      check({name, "_ct_t10"}, ct, exp);
      last_ct = exp;
   endtask

   initial begin
      vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                  pt:  128'h00112233445566778899aabbccddeeff,
                  st0: 128'h00102030405060708090a0b0c0d0e0f0,
                  ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  pt:  128'h3243f6a8885a308d313198a2e0370734,
                  st0: 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                  ct:  128'h3925841d02dc09fbdc118597196a0b32};
      vecs[2] = '{key: 128'h0,
                  pt:  128'h0,
                  st0: 128'h0,
                  ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rst_valid", {127'd0, valid}, 128'd0);
         check("rst_ct", ct, 128'd0);
      end

      for (int i = 0; i < 3; i++) begin
         start_op(vecs[i].key, vecs[i].pt);
         check($sformatf("v%0d_state0", i), dut.state_q, vecs[i].st0);
         finish_op($sformatf("v%0d", i), vecs[i].ct, 0);
      end

      for (int i = 0; i < 50; i++) begin
         tick();
         check("hold_valid", {127'd0, valid}, 128'd1);
         check("hold_ct", ct, last_ct);
      end

      start_op(vecs[0].key, vecs[0].pt);
      finish_op("retrig", vecs[0].ct, 0);

      start_op(vecs[1].key, vecs[1].pt);
      tick();
      load = 1'b0;
      tick();
      load = 1'b1;
      key  = ~vecs[1].key;
      pt   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      tick();
      finish_op("busy_chg", vecs[1].ct, 3);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("no_restart", {127'd0, valid}, 128'd1);
      end

      start_op(vecs[2].key, vecs[2].pt);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_valid", {127'd0, valid}, 128'd0);
      check("midrst_ct", ct, 128'd0);
      rst_n = 1'b1;
      load  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("postrst_valid", {127'd0, valid}, 128'd0);
      end
      last_ct = '0;

      rst_n = 1'b0;
      load  = 1'b1;
      key   = vecs[0].key;
      pt    = vecs[0].pt;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rstload_state0", dut.state_q, vecs[0].st0);
      finish_op("rstload", vecs[0].ct, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
